// File: rtl/mac_sequencer.sv
// Job sequencer for a single fp16 MAC processing element: clears the PE, streams
// operand pairs into it, flushes its pipeline with zero beats and captures the result.
module mac_sequencer #(
   parameter int W     = 16,
   parameter int LEN_W = 8,
   parameter int DRAIN = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   output logic             pe_clr,
   output logic             pe_en,
   output logic [W-1:0]     pe_a,
   output logic [W-1:0]     pe_b,
   input  logic [W-1:0]     pe_p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_SETTLE,
      S_HOLD
   } state_t;

   localparam logic [LEN_W-1:0] DRAIN_LAST = LEN_W'(DRAIN - 1);
   localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [LEN_W-1:0] drain_q, drain_d;
   logic             pe_en_q, pe_en_d;
   logic [W-1:0]     pe_a_q, pe_a_d;
   logic [W-1:0]     pe_b_q, pe_b_d;
   logic [W-1:0]     out_data_q, out_data_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rem_q      <= '0;
         drain_q    <= '0;
         pe_en_q    <= 1'b0;
         pe_a_q     <= '0;
         pe_b_q     <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         drain_q    <= drain_d;
         pe_en_q    <= pe_en_d;
         pe_a_q     <= pe_a_d;
         pe_b_q     <= pe_b_d;
         out_data_q <= out_data_d;
      end
   end

   // pe_en is re-decided every edge; operands hold unless a transfer or flush beat loads them.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      drain_d    = drain_q;
      pe_en_d    = 1'b0;
      pe_a_d     = pe_a_q;
      pe_b_d     = pe_b_q;
      out_data_d = out_data_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  rem_d   = len;
                  state_d = S_CLEAR;
               end else begin
                  out_data_d = '0;
                  state_d    = S_HOLD;
               end
            end
         end
         S_CLEAR: begin
            state_d = S_FEED;
         end
         S_FEED: begin
            if (in_valid) begin
               pe_en_d = 1'b1;
               pe_a_d  = in_a;
               pe_b_d  = in_b;
               rem_d   = rem_q - ONE;
               if (rem_q == ONE) begin
                  drain_d = DRAIN_LAST;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            pe_en_d = 1'b1;
            pe_a_d  = '0;
            pe_b_d  = '0;
            if (drain_q == '0) begin
               state_d = S_SETTLE;
            end else begin
               drain_d = drain_q - ONE;
            end
         end
         S_SETTLE: begin
            out_data_d = pe_p;
            state_d    = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == S_FEED);
   assign pe_clr    = (state_q == S_CLEAR);
   assign out_valid = (state_q == S_HOLD);
   assign busy      = (state_q != S_IDLE);
   assign pe_en     = pe_en_q;
   assign pe_a      = pe_a_q;
   assign pe_b      = pe_b_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural fp16 accumulator PE, per-cycle beat/result
// monitor against the job's operand list, and directed jobs with literal results.
module tb_mac_sequencer;
   localparam int W       = 16;
   localparam int LEN_W   = 8;
   localparam int DRAIN_N = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic             in_valid = 1'b0;
   logic [W-1:0]     in_a = '0;
   logic [W-1:0]     in_b = '0;
   logic             out_ready = 1'b0;
   logic             in_ready, pe_clr, pe_en, out_valid, busy;
   logic [W-1:0]     pe_a, pe_b, pe_p, out_data;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] job_a [256];
   logic [15:0] job_b [256];
   int          job_n = 0;
   int          beat_idx = 0;
   int          clr_cnt = 0;
   int          zero_cnt = 0;
   logic [15:0] exp_res = '0;
   logic [15:0] acc;

   always #5 clk = ~clk;

   mac_sequencer #(.W(W), .LEN_W(LEN_W), .DRAIN(DRAIN_N)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .pe_clr(pe_clr), .pe_en(pe_en), .pe_a(pe_a), .pe_b(pe_b), .pe_p(pe_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   function automatic real h2r(input logic [15:0] h);
      int  e;
      int  m;
      real v;
      e = int'(h[14:10]);
      m = int'(h[9:0]);
      if (e == 0) v = m * (2.0 ** (-24));
      else        v = (1.0 + m / 1024.0) * (2.0 ** (e - 15));
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] r2h(input real r);
      logic s;
      real  v;
      int   e;
      int   m;
      if (r == 0.0) return 16'h0000;
      s = (r < 0.0);
      v = s ? -r : r;
      e = 15;
      while (v >= 2.0) begin v = v / 2.0; e++; end
      while (v < 1.0)  begin v = v * 2.0; e--; end
      m = int'((v - 1.0) * 1024.0);
      if (m == 1024) begin m = 0; e++; end
      return {s, 5'(e), 10'(m)};
   endfunction

   // Stand-in PE: single-cycle fp16 accumulator, rounded to fp16 after every beat.
   always @(posedge clk or posedge reset) begin
      if (reset)       acc <= '0;
      else if (pe_clr) acc <= '0;
      else if (pe_en)  acc <= r2h(h2r(acc) + h2r(pe_a) * h2r(pe_b));
   end
   assign pe_p = acc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare: each enabled beat must be the next job operand, then zero flush beats.
   always @(negedge clk) begin
      if (!reset) begin
         if (in_ready) check("ready_implies_busy", 32'(busy), 32'd1);
         if (!busy) check("idle_pe_quiet", 32'({pe_en, pe_clr}), 32'd0);
         if (out_valid) begin
            check("out_data_vs_model", 32'(out_data), 32'(exp_res));
            check("hold_not_ready", 32'(in_ready), 32'd0);
         end
         if (pe_clr) begin
            clr_cnt++;
            beat_idx = 0;
            zero_cnt = 0;
            check("clr_without_en", 32'(pe_en), 32'd0);
         end
         if (pe_en) begin
            if (beat_idx < job_n) begin
               check("beat_a", 32'(pe_a), 32'(job_a[beat_idx]));
               check("beat_b", 32'(pe_b), 32'(job_b[beat_idx]));
            end else begin
               check("flush_zero", 32'({pe_a, pe_b}), 32'd0);
               zero_cnt++;
            end
            beat_idx++;
         end
      end
   end

   task automatic run_job(input int n, input int gap, input int hold_wait, input logic [15:0] lit);
      logic [15:0] m;
      logic [15:0] held;
      int          t;
      m = '0;
      for (int i = 0; i < n; i++) m = r2h(h2r(m) + h2r(job_a[i]) * h2r(job_b[i]));
      check("model_pin", 32'(m), 32'(lit));
      exp_res  = m;
      job_n    = n;
      beat_idx = 0;
      clr_cnt  = 0;
      zero_cnt = 0;
      start    = 1'b1;
      len      = LEN_W'(n);
      @(negedge clk);
      start = 1'b0;
      if (n == 0) check("len0_hold_next_cycle", 32'(out_valid), 32'd1);
      for (int i = 0; i < n; i++) begin
         t = 0;
         while (!in_ready && t < 20) begin @(negedge clk); t++; end
         check("in_ready_wait", 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_a     = job_a[i];
         in_b     = job_b[i];
         @(negedge clk);
         if (gap > 0 && i < n - 1) begin
            in_valid = 1'b0;
            for (int k = 0; k < gap; k++) begin
               @(negedge clk);
               check("gap_pe_en", 32'(pe_en), 32'd0);
            end
         end
      end
      in_valid = 1'b0;
      t = 0;
      while (!out_valid && t < 50) begin @(negedge clk); t++; end
      check("out_valid_wait", 32'(out_valid), 32'd1);
      check("result_literal", 32'(out_data), 32'(lit));
      held = out_data;
      for (int k = 0; k < hold_wait; k++) begin
         start    = (k % 2 == 0);
         len      = LEN_W'(3);
         in_valid = 1'b1;
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data_stable", 32'(out_data), 32'(held));
         check("hold_busy", 32'(busy), 32'd1);
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("after_hs_valid", 32'(out_valid), 32'd0);
      check("after_hs_busy", 32'(busy), 32'd0);
      check("clr_pulses", 32'(clr_cnt), (n != 0) ? 32'd1 : 32'd0);
      check("real_beats", 32'(beat_idx - zero_cnt), 32'(n));
      check("zero_beats", 32'(zero_cnt), (n != 0) ? 32'(DRAIN_N) : 32'd0);
      $display("job len=%0d gap=%0d hold=%0d result=0x%04h expected=0x%04h", n, gap, hold_wait, held, lit);
   endtask

   initial begin
      #2 reset = 1'b1;
      #1;
      check("rst_ctrl", 32'({pe_clr, pe_en, out_valid, in_ready, busy}), 32'd0);
      check("rst_data", 32'({pe_a, pe_b}), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 1*2 + 2*2 = 6, streamed back-to-back
      job_a[0] = 16'h3C00; job_b[0] = 16'h4000;
      job_a[1] = 16'h4000; job_b[1] = 16'h4000;
      run_job(2, 0, 0, 16'h4600);

      // three 1*1 pairs with two idle cycles between them, started right after the handshake
      for (int i = 0; i < 3; i++) begin job_a[i] = 16'h3C00; job_b[i] = 16'h3C00; end
      run_job(3, 2, 0, 16'h4200);

      // empty job, result held five cycles while start/in_valid pulses are ignored
      run_job(0, 0, 5, 16'h0000);

      // abandon a four-pair job after its first pair
      for (int i = 0; i < 4; i++) begin job_a[i] = 16'h4000; job_b[i] = 16'h4000; end
      job_n = 4; beat_idx = 0;
      start = 1'b1; len = LEN_W'(4);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("rst_job_feed", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_a = job_a[0]; in_b = job_b[0];
      @(negedge clk);
      in_valid = 1'b0;
      check("rst_job_beat", 32'(pe_en), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("midjob_rst_ctrl", 32'({pe_clr, pe_en, out_valid, in_ready, busy}), 32'd0);
      check("midjob_rst_data", 32'({pe_a, pe_b}), 32'd0);
      check("midjob_rst_out", 32'(out_data), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      $display("reset mid-job: outputs cleared asynchronously");

      // 2*3 = 6 after the abandoned job
      job_a[0] = 16'h4000; job_b[0] = 16'h4200;
      run_job(1, 0, 0, 16'h4600);

      // back-to-back: must not inherit the previous 6.0 accumulator
      job_a[0] = 16'h3C00; job_b[0] = 16'h3C00;
      run_job(1, 0, 0, 16'h3C00);

      // maximum length: 255 * (1*1) = 255.0
      for (int i = 0; i < 255; i++) begin job_a[i] = 16'h3C00; job_b[i] = 16'h3C00; end
      run_job(255, 0, 0, 16'h5BF8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter W, default 16: operand/result width, IEEE fp16 bit pattern.
REQ-002 Parameter LEN_W, default 8: width of the dot-product length field.
REQ-003 Parameter DRAIN, default 3, range 1-15: zero-operand flush beats issued to the PE after the last real pair.
REQ-004 clk  input  1  clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle job request, sampled only in IDLE.
REQ-007 len  input  LEN_W  number of operand pairs in the job, sampled with start.
REQ-008 in_valid / in_ready  input / output  1 each  operand-pair handshake.
REQ-009 in_a, in_b  input  W each  operand pair.
REQ-010 pe_clr  output  1  one-cycle accumulator clear to the PE.
REQ-011 pe_en  output  1  PE enable.
REQ-012 pe_a, pe_b  output  W each  PE operands.
REQ-013 pe_p  input  W  PE accumulator value.
REQ-014 out_valid / out_ready  output / input  1 each  result handshake.
REQ-015 out_data  output  W  captured dot-product result.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The block SHALL implement states IDLE, CLEAR, FEED, DRAIN, SETTLE, HOLD.
REQ-018 IDLE: start=1 with len!=0 SHALL latch len into the remaining counter and go to CLEAR; start=1 with len=0 SHALL load out_data=0 and go to HOLD; start=0 stays.
REQ-019 CLEAR: pe_clr=1 and pe_en=0 for exactly one cycle, then FEED.
REQ-020 FEED: in_ready=1; a transfer occurs when in_valid&&in_ready at a posedge.
REQ-021 Each transfer SHALL register pe_a<=in_a, pe_b<=in_b, pe_en<=1 at that edge and decrement the remaining counter.
REQ-022 A FEED cycle without a transfer SHALL register pe_en<=0; pe_a/pe_b hold their value.
REQ-023 The transfer that brings remaining to 0 SHALL move to DRAIN; in_ready SHALL be 0 outside FEED.
REQ-024 DRAIN: pe_en=1, pe_a=pe_b=0 for exactly DRAIN cycles, counted by a dedicated counter, then SETTLE.
REQ-025 SETTLE: pe_en=0 for one cycle; at its closing edge out_data<=pe_p, go to HOLD.
REQ-026 HOLD: out_valid=1 and out_data stable; out_valid&&out_ready at a posedge SHALL return to IDLE with out_valid=0 the next cycle.
REQ-027 start outside IDLE SHALL be ignored; in_valid outside FEED SHALL be ignored with no transfer.
REQ-028 pe_en, pe_a, pe_b, pe_clr, out_valid, out_data, in_ready and busy SHALL be registered or decoded from state only, with no combinational path from any input.
REQ-029 Back-to-back jobs: start in the IDLE cycle following a HOLD handshake SHALL be accepted with no extra bubble.
REQ-030 Counters SHALL be LEN_W bits; len = 2^LEN_W-1 SHALL complete without wrap.

Reset
REQ-031 On reset, state=IDLE and counters=0 immediately, independent of clk.
REQ-032 On reset, pe_clr=0, pe_en=0, pe_a=0, pe_b=0, out_valid=0, out_data=0, in_ready=0, busy=0.
REQ-033 Reset mid-job SHALL abandon the job with no output; the next job SHALL start from CLEAR normally.

Verification (bench connects the team fp16 MAC PE, DRAIN=3)
REQ-034 start, len=2; pairs (0x3C00,0x4000),(0x4000,0x4000) back-to-back -> out_valid with out_data=0x4600 (6.0); exactly one pe_clr pulse; 3 zero-operand beats.
REQ-035 len=3, in_valid deasserted 2 cycles between each pair, pairs (0x3C00,0x3C00) x3 -> out_data=0x4200 (3.0); pe_en=0 on every gap cycle.
REQ-036 len=0 -> HOLD next cycle, out_data=0x0000, pe_en and pe_clr never asserted.
REQ-037 out_ready held low 5 cycles in HOLD -> out_valid and out_data stable 5 cycles; start pulses during HOLD ignored; busy=1.
REQ-038 reset asserted in FEED after 1 of 4 pairs -> all outputs 0 same cycle; a new job len=1 (0x4000,0x4200) -> out_data=0x4600.
REQ-039 Two jobs back-to-back, second start in the cycle after the handshake -> second result unaffected by the first accumulator value.
